// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared types and constants for the forwarding/hazard unit
package mips_ctrl_pkg;

  // Entries are sized for the widest supported configuration; narrower
  // register addresses are zero-extended on the way in.
  localparam int RA_W_MAX   = 8;
  localparam int RDY_W      = 2;
  localparam int FWD_SEL_RF = 0;

  typedef struct packed {
    logic                valid;
    logic [RA_W_MAX-1:0] wr_addr;
    logic [RDY_W-1:0]    ready_cnt;
  } stage_entry_t;

endpackage

// File: rtl/fwd_match.sv
// rtl/fwd_match.sv - youngest-first producer search for one source operand
module fwd_match
  import mips_ctrl_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int RA_W  = 5,
  parameter int SEL_W = $clog2(DEPTH + 1)
) (
  input  logic                     i_use,
  input  logic [RA_W-1:0]          i_addr,
  input  stage_entry_t [DEPTH-1:0] i_stages,
  output logic [SEL_W-1:0]         o_sel,
  output logic                     o_hazard
);

  logic w_found;

  always_comb begin
    o_sel    = SEL_W'(FWD_SEL_RF);
    o_hazard = 1'b0;
    w_found  = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (!w_found && i_stages[k].valid &&
          i_stages[k].wr_addr == RA_W_MAX'(i_addr)) begin
        w_found = 1'b1;
        // A younger producer that is not ready must stall, never fall through to older data.
        if (i_stages[k].ready_cnt != '0) o_hazard = 1'b1;
        else                             o_sel    = SEL_W'(k + 1);
      end
    end
    if (!i_use || i_addr == '0) begin
      o_sel    = SEL_W'(FWD_SEL_RF);
      o_hazard = 1'b0;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - operand forwarding select and load-use interlock
module fwd_hazard_unit
  import mips_ctrl_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int LOAD_LAT = 1,
  parameter int RA_W     = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         id_valid,
  input  logic [RA_W-1:0]              id_rs,
  input  logic [RA_W-1:0]              id_rt,
  input  logic                         id_use_rs,
  input  logic                         id_use_rt,
  input  logic                         id_wr_en,
  input  logic [RA_W-1:0]              id_wr_addr,
  input  logic                         id_is_load,
  input  logic                         flush,
  input  logic                         stall_ext,
  output logic [$clog2(DEPTH+1)-1:0]   fwd_sel_a,
  output logic [$clog2(DEPTH+1)-1:0]   fwd_sel_b,
  output logic                         stall,
  output logic [31:0]                  stall_count
);

  localparam int SEL_W = $clog2(DEPTH + 1);

  stage_entry_t [DEPTH-1:0] r_stage;
  logic [31:0]              r_stall_count;
  stage_entry_t             w_new;
  logic                     w_haz_a;
  logic                     w_haz_b;
  logic                     w_stall;

  fwd_match #(.DEPTH(DEPTH), .RA_W(RA_W), .SEL_W(SEL_W)) u_match_rs (
    .i_use    (id_use_rs),
    .i_addr   (id_rs),
    .i_stages (r_stage),
    .o_sel    (fwd_sel_a),
    .o_hazard (w_haz_a)
  );

  fwd_match #(.DEPTH(DEPTH), .RA_W(RA_W), .SEL_W(SEL_W)) u_match_rt (
    .i_use    (id_use_rt),
    .i_addr   (id_rt),
    .i_stages (r_stage),
    .o_sel    (fwd_sel_b),
    .o_hazard (w_haz_b)
  );

  assign w_stall = id_valid & (w_haz_a | w_haz_b) & ~flush;

  always_comb begin
    w_new = '0;
    if (id_valid && id_wr_en && id_wr_addr != '0 && !w_stall && !flush) begin
      w_new.valid     = 1'b1;
      w_new.wr_addr   = RA_W_MAX'(id_wr_addr);
      w_new.ready_cnt = id_is_load ? RDY_W'(LOAD_LAT) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stage       <= '0;
      r_stall_count <= '0;
    end else if (!stall_ext) begin
      r_stage[0] <= w_new;
      for (int k = 1; k < DEPTH; k++) begin
        r_stage[k].valid     <= r_stage[k-1].valid;
        r_stage[k].wr_addr   <= r_stage[k-1].wr_addr;
        r_stage[k].ready_cnt <= (r_stage[k-1].ready_cnt != '0) ?
                                r_stage[k-1].ready_cnt - RDY_W'(1) : '0;
      end
      r_stall_count <= r_stall_count + {31'd0, w_stall};
    end
  end

  assign stall       = w_stall;
  assign stall_count = r_stall_count;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - directed-vector bench for fwd_hazard_unit
module tb_fwd_hazard_unit;

  logic       clk = 1'b0;
  logic       reset, id_valid, id_use_rs, id_use_rt, id_wr_en, id_is_load, flush, stall_ext;
  logic [4:0] id_rs, id_rt, id_wr_addr;

  logic [1:0]  a_sel_a, a_sel_b, b_sel_a, b_sel_b;
  logic        a_stall, b_stall;
  logic [31:0] a_count, b_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.DEPTH(2), .LOAD_LAT(1), .RA_W(5)) u_dut_a (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en),
    .id_wr_addr(id_wr_addr), .id_is_load(id_is_load), .flush(flush),
    .stall_ext(stall_ext), .fwd_sel_a(a_sel_a), .fwd_sel_b(a_sel_b),
    .stall(a_stall), .stall_count(a_count)
  );

  fwd_hazard_unit #(.DEPTH(2), .LOAD_LAT(2), .RA_W(5)) u_dut_b (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en),
    .id_wr_addr(id_wr_addr), .id_is_load(id_is_load), .flush(flush),
    .stall_ext(stall_ext), .fwd_sel_a(b_sel_a), .fwd_sel_b(b_sel_b),
    .stall(b_stall), .stall_count(b_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic we,
                        input logic [4:0] wa, input logic ld);
    id_valid = v;  id_rs = rs;  id_rt = rt;  id_use_rs = urs;  id_use_rt = urt;
    id_wr_en = we; id_wr_addr = wa; id_is_load = ld;
    #1;
  endtask

  task automatic idle();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; stall_ext = 1'b0;
    idle();
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_sel_a", 32'(a_sel_a), 0);
    chk("rst_sel_b", 32'(a_sel_b), 0);
    chk("rst_stall", 32'(a_stall), 0);
    chk("rst_count", a_count, 0);

    // ALU producer r8 forwarded from stage 1 then stage 2
    set_id(1, 5'd0, 5'd0, 0, 0, 1, 5'd8, 0);
    tick();
    set_id(1, 5'd8, 5'd3, 1, 1, 1, 5'd10, 0);
    chk("alu_s1_sel_a", 32'(a_sel_a), 1);
    chk("alu_s1_sel_b", 32'(a_sel_b), 0);
    chk("alu_s1_stall", 32'(a_stall), 0);
    tick();
    set_id(1, 5'd8, 5'd10, 1, 1, 0, 5'd0, 0);
    chk("alu_s2_sel_a", 32'(a_sel_a), 2);
    chk("alu_s2_sel_b", 32'(a_sel_b), 1);
    tick();

    // r0 writes never create a producer
    set_id(1, 5'd0, 5'd0, 0, 0, 1, 5'd0, 0);
    tick();
    set_id(1, 5'd0, 5'd0, 1, 1, 0, 5'd0, 0);
    chk("r0_sel_a", 32'(a_sel_a), 0);
    chk("r0_sel_b", 32'(a_sel_b), 0);
    chk("r0_stall", 32'(a_stall), 0);
    idle(); tick(); tick();

    // Load-use on rt with LOAD_LAT=1
    set_id(1, 5'd0, 5'd0, 0, 0, 1, 5'd9, 1);
    tick();
    set_id(1, 5'd0, 5'd9, 0, 1, 0, 5'd0, 0);
    chk("lu_stall", 32'(a_stall), 1);
    chk("lu_sel_b", 32'(a_sel_b), 0);
    chk("lu_count0", a_count, 0);
    tick();
    chk("lu_release", 32'(a_stall), 0);
    chk("lu_sel_b2", 32'(a_sel_b), 2);
    chk("lu_count1", a_count, 1);
    idle(); tick(); tick();

    // External freeze during interlock
    set_id(1, 5'd0, 5'd0, 0, 0, 1, 5'd9, 1);
    tick();
    set_id(1, 5'd0, 5'd9, 0, 1, 0, 5'd0, 0);
    chk("frz_stall_pre", 32'(a_stall), 1);
    stall_ext = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("frz_stall", 32'(a_stall), 1);
      chk("frz_count", a_count, 1);
      chk("frz_sel_b", 32'(a_sel_b), 0);
    end
    stall_ext = 1'b0;
    #1;
    chk("frz_after_stall", 32'(a_stall), 1);
    tick();
    chk("frz_resume_stall", 32'(a_stall), 0);
    chk("frz_resume_sel_b", 32'(a_sel_b), 2);
    chk("frz_resume_count", a_count, 2);
    idle(); tick(); tick();

    // Flush suppresses the interlock and turns the decode slot into a bubble
    set_id(1, 5'd0, 5'd0, 0, 0, 1, 5'd9, 1);
    tick();
    flush = 1'b1;
    set_id(1, 5'd0, 5'd9, 0, 1, 1, 5'd12, 0);
    chk("fl_stall", 32'(a_stall), 0);
    chk("fl_sel_b", 32'(a_sel_b), 0);
    tick();
    flush = 1'b0;
    set_id(1, 5'd12, 5'd9, 1, 1, 0, 5'd0, 0);
    chk("fl_bubble_sel_a", 32'(a_sel_a), 0);
    chk("fl_sel_b2", 32'(a_sel_b), 2);
    chk("fl_count", a_count, 2);
    idle(); tick(); tick();

    // Reset in the middle of an interlock
    set_id(1, 5'd0, 5'd0, 0, 0, 1, 5'd9, 1);
    tick();
    set_id(1, 5'd0, 5'd9, 0, 1, 0, 5'd0, 0);
    chk("mrst_stall_pre", 32'(a_stall), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("mrst_stall", 32'(a_stall), 0);
    chk("mrst_sel_b", 32'(a_sel_b), 0);
    chk("mrst_count", a_count, 0);
    idle(); tick();

    // LOAD_LAT=2: youngest (a load) shadows an older ready producer of r8
    set_id(1, 5'd0, 5'd0, 0, 0, 1, 5'd8, 0);
    tick();
    set_id(1, 5'd0, 5'd0, 0, 0, 1, 5'd8, 1);
    tick();
    set_id(1, 5'd8, 5'd0, 1, 0, 0, 5'd0, 0);
    chk("yw_stall1", 32'(b_stall), 1);
    chk("yw_sel1", 32'(b_sel_a), 0);
    tick();
    chk("yw_stall2", 32'(b_stall), 1);
    chk("yw_sel2", 32'(b_sel_a), 0);
    tick();
    chk("yw_stall3", 32'(b_stall), 0);
    chk("yw_sel3", 32'(b_sel_a), 0);
    chk("yw_count", b_count, 2);
    idle(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 Parameter DEPTH, default 2, range 1..4: number of in-flight stages tracked past decode (stage 1 = youngest).
REQ-002 Parameter LOAD_LAT, default 1, range 1..3: cycles after entering stage 1 before a load result is forwardable.
REQ-003 Parameter RA_W, default 5: register address width.
REQ-004 Port clk  input  1: sole clock; all state updates on rising edge.
REQ-005 Port reset  input  1: synchronous, active-high reset.
REQ-006 Port id_valid  input  1: decode-stage instruction present.
REQ-007 Port id_rs, id_rt  input  RA_W each: source register addresses.
REQ-008 Port id_use_rs, id_use_rt  input  1 each: source actually read.
REQ-009 Port id_wr_en  input  1: instruction writes a register.
REQ-010 Port id_wr_addr  input  RA_W: destination register.
REQ-011 Port id_is_load  input  1: destination produced by a memory/UART load.
REQ-012 Port flush  input  1: taken branch/jump; squash decode instruction.
REQ-013 Port stall_ext  input  1: external freeze (memory/UART); pipeline holds.
REQ-014 Port fwd_sel_a, fwd_sel_b  output  clog2(DEPTH+1): operand source; 0 = register file, k = stage k result.
REQ-015 Port stall  output  1: load-use interlock; hold PC and decode, insert bubble.
REQ-016 Port stall_count  output  32: number of cycles with stall asserted, wraps at 2^32.

Function
REQ-017 Tracker SHALL hold per stage: valid, wr_addr, ready_cnt (clog2(LOAD_LAT+1) bits).
REQ-018 Per source operand: ignored if use bit low or address 0; else search stages 1..DEPTH youngest first; first valid entry with matching wr_addr wins.
REQ-019 Winner with ready_cnt==0 -> fwd_sel = stage index; winner with ready_cnt>0 -> hazard; no winner -> fwd_sel = 0.
REQ-020 During a hazard the affected fwd_sel SHALL be 0.
REQ-021 stall = id_valid & (hazard on rs | hazard on rt) & ~flush; combinational, same cycle.
REQ-022 When stall_ext=1: all tracker state and stall_count hold; stall/fwd_sel still evaluated from held state.
REQ-023 When stall_ext=0: stage k+1 <= stage k; entries leaving stage DEPTH are discarded; each shifted ready_cnt decrements, saturating at 0.
REQ-024 When stall_ext=0, stage 1 <= new entry iff id_valid & id_wr_en & id_wr_addr!=0 & ~stall & ~flush; else bubble (valid=0).
REQ-025 New entry ready_cnt = LOAD_LAT if id_is_load, else 0.
REQ-026 flush SHALL NOT invalidate stages 1..DEPTH (older instructions complete).
REQ-027 flush and stall_ext together: stall_ext wins (no shift); flush still forces stall=0.
REQ-028 stall_count increments when stall=1 and stall_ext=0.
REQ-029 Two stages matching the same register: youngest wins, even if not ready (stall rather than forward stale data).

Reset
REQ-030 On reset=1 at clk edge: all valid bits 0, ready_cnt 0, stall_count 0; reset overrides stall_ext and flush.
REQ-031 Consequently, in cycle after reset: fwd_sel_a=fwd_sel_b=0, stall=0.
REQ-032 Reset mid-interlock SHALL abort the interlock; no residual stall.

Structure
REQ-033 Package mips_ctrl_pkg SHALL hold the stage-entry typedef and fwd_sel encoding constant for register file (0).
REQ-034 One sub-module fwd_match SHALL implement the per-operand priority search, instantiated twice (rs, rt).

Verification
REQ-035 DEPTH=2: ADDU writing r8, then ADDU reading r8 next cycle -> fwd_sel_a=1, stall=0; one cycle later reader -> fwd_sel_a=2.
REQ-036 LOAD_LAT=1: LW r9, then reader of r9 as rt -> stall=1 one cycle, then fwd_sel_b=2, stall_count=1.
REQ-037 Write to r0 followed by reader of r0 -> fwd_sel=0, stall=0, no entry created.
REQ-038 r8 written in stages 1 and 2 (stage 1 a load, LOAD_LAT=2) -> stall=1 two cycles, never fwd_sel=2.
REQ-039 LW r9 issued, stall_ext=1 for 3 cycles during interlock -> stall held, stall_count unchanged, tracker frozen; resumes identically after release.
REQ-040 flush with hazarding decode instruction -> stall=0, bubble inserted; reset asserted mid-interlock -> next cycle all outputs 0.
